gx4000_asic_ram_ctrl: RTL and testbench
=======================================

# gx4000_asic_ram_ctrl

Responder side of the GX4000 ASIC RAM interface. It owns the 16 KB ASIC RAM and serves two requesters: the Z80 through the 0x4000–0x7FFF ASIC page, and the video/sprite engine through its `asic_ram_*` port. Both requesters are buffered one deep and arbitrated onto a single-port synchronous RAM, with video priority and a bounded CPU wait. The sprite pixel region stores nibbles only.

## Interface
- `ADDR_W`, 14: ASIC RAM address width (16 KB).
- `MAX_WAIT`, 3: number of grant cycles the CPU may lose to video before it is forced to win.
- `SPR_TOP`, 14'h0FFF: last address of the sprite pixel region (the region starts at 0x0000).
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `plus_mode` in 1: when 0, all new requests are ignored.
- `asic_en` in 1: ASIC page mapped at 0x4000–0x7FFF.
- `cpu_addr` in 16; `cpu_din` in 8; `cpu_wr` in 1; `cpu_rd` in 1: Z80 strobes, level signals that may span many cycles.
- `cpu_dout` out 8: last CPU read data.
- `cpu_rdy` out 1: 1-cycle pulse when a CPU access completes.
- `cpu_busy` out 1: CPU access pending (drives Z80 WAIT).
- `vid_addr` in 14; `vid_rd` in 1; `vid_wr` in 1; `vid_din` in 8: video requests, single-cycle strobes.
- `vid_q` out 8: read data.
- `vid_ack` out 1: 1-cycle pulse when a video access completes.
- `vid_ovf` out 1: sticky; an unserved video request was overwritten.
- `cpu_err` out 1: sticky; a CPU edge arrived while `cpu_busy`.

## Operation
- **CPU request capture**
  - A CPU request is a rising edge of `cpu_wr` or `cpu_rd` with `cpu_addr[15:14]==2'b01`, `asic_en=1` and `plus_mode=1`.
  - The request latches `{we, cpu_addr[13:0], cpu_din}` into `cpu_pend`.
  - If `cpu_wr` and `cpu_rd` rise together, the write is taken.
  - An edge arriving while `cpu_pend` is valid is dropped and sets `cpu_err`.
- **Video request capture**
  - Any cycle with `vid_rd|vid_wr` and `plus_mode=1` latches into `vid_pend`; `vid_wr` wins over `vid_rd` if both are set.
  - If `vid_pend` is still valid and not granted in that cycle, the new request overwrites it and `vid_ovf` is set.
- **Arbiter states**
  - IDLE: no grant.
  - GNT_VID: video granted.
  - GNT_CPU: CPU granted.
  - Exactly one grant is issued per cycle.
  - Selection: if `cpu_pend` is valid and `cpu_age==MAX_WAIT`, the CPU wins. Otherwise, if `vid_pend` is valid, video wins. Otherwise, if `cpu_pend` is valid, the CPU wins. Otherwise IDLE.
  - A granted pending entry clears in the grant cycle.
  - `cpu_age` (2 bits, saturating) increments each cycle the CPU is pending but not granted. It clears on CPU grant and on reset.
- **RAM access**
  - A grant drives the RAM address, write enable and write data in the same cycle. Read data is available one cycle later.
  - Writes to addresses 0x0000..`SPR_TOP` store `{4'h0, din[3:0]}`. All other addresses store the full byte.
- **Completion**
  - One cycle after a grant, the owner receives its pulse (`vid_ack` or `cpu_rdy`).
  - On reads, `vid_q` or `cpu_dout` loads the RAM output.
  - `vid_q` and `cpu_dout` hold their value until the next read for that requester.
- **`cpu_busy`** is high from the cycle after the CPU edge through the `cpu_rdy` cycle inclusive.

## Timing
- **Reset values:** `cpu_dout`=0, `cpu_rdy`=0, `cpu_busy`=0, `vid_q`=0, `vid_ack`=0, `vid_ovf`=0, `cpu_err`=0, state IDLE, both pending entries invalid, edge detectors primed with the current strobe levels.
- **Reset mid-operation:** pending and in-flight accesses are discarded and no ack or rdy is issued. RAM contents are preserved.
- **Uncontested latency:** request in cycle 0 → grant in cycle 1 → `ack`/`rdy` and data in cycle 2.
- **CPU worst case:** grant at most `MAX_WAIT`+1 cycles after capture under continuous video traffic; `rdy` one cycle later.
- **Simultaneous CPU and video write to the same address (CPU not aged):** video writes first, then the CPU. The final value is the CPU's.
- **Read-after-write:** a read granted in the cycle after a write to the same address returns the new value.
- **Address wrap:** `vid_addr` and `cpu_addr[13:0]` are used as-is. There is no overflow and no aliasing beyond 14 bits.
- **`plus_mode` deasserted** while requests are pending: pending requests complete normally; new ones are ignored.

## Structure
- **Package `gx4000_asic_pkg`:**
  - `ASIC_ADDR_W` = 14.
  - `ASIC_PAGE` = 2'b01.
  - `SPR_PIX_BASE` = 14'h0000; `SPR_PIX_TOP` = 14'h0FFF.
  - `arb_state_t` enum {IDLE, GNT_VID, GNT_CPU}.
  - `asic_req_t` struct {valid, we, addr[13:0], data[7:0]}.
- **Sub-module `gx4000_asic_bram`:** 16K×8 single-port synchronous RAM, 1-cycle read latency, write-first, no reset of contents.
- Everything else lives in `gx4000_asic_ram_ctrl`: edge detect, pending registers, arbiter, completion pipeline.

## Test plan
- **CPU write/read:** after reset, CPU write 0x5234=0xA7, then CPU read 0x5234 → `cpu_rdy` two cycles after each edge, `cpu_dout`=0xA7, `cpu_busy` high for 2 cycles each time.
- **Nibble masking:** video write 0x0010=0xFF, then video read 0x0010 → `vid_ack` at +2, `vid_q`=0x0F. Video write 0x2000=0xFF → read back 0xFF.
- **Starvation bound:** `vid_rd` every cycle plus a CPU write at 0x4100 → CPU granted exactly 4 cycles after capture, `cpu_rdy` at +5, `vid_ovf`=1 after the stolen slot.
- **Same-address collision:** in the same cycle, video write 0x0300=0x11 and CPU write 0x4300=0x22 → video ack first, CPU rdy one cycle later, read-back 0x22.
- **Busy protocol error:** second CPU `cpu_wr` rising edge while `cpu_busy` → `cpu_err`=1, RAM unchanged by the second write.
- **Reset and gating:** reset asserted one cycle after a video read request → no `vid_ack`, outputs at reset values. With `plus_mode`=0, a CPU write produces no `rdy` and no RAM change.

Source files
------------

// File: rtl/gx4000_asic_pkg.sv
// Shared constants, types and the sprite-nibble store rule for the GX4000 ASIC RAM responder.
package gx4000_asic_pkg;

   localparam int unsigned              ASIC_ADDR_W  = 14;
   localparam logic [1:0]               ASIC_PAGE    = 2'b01;
   localparam logic [ASIC_ADDR_W-1:0]   SPR_PIX_BASE = 14'h0000;
   localparam logic [ASIC_ADDR_W-1:0]   SPR_PIX_TOP  = 14'h0FFF;

   typedef enum logic [1:0] {
      IDLE,
      GNT_VID,
      GNT_CPU
   } arb_state_t;

   typedef struct packed {
      logic                   valid;
      logic                   we;
      logic [ASIC_ADDR_W-1:0] addr;
      logic [7:0]             data;
   } asic_req_t;

   // Sprite pixel region starts at address 0, so only the upper bound needs checking.
   function automatic logic [7:0] spr_store_byte(input logic [ASIC_ADDR_W-1:0] addr,
                                                 input logic [ASIC_ADDR_W-1:0] top,
                                                 input logic [7:0]             din);
      return (addr <= top) ? {4'h0, din[3:0]} : din;
   endfunction

endpackage

// File: rtl/gx4000_asic_bram.sv
// 16K x 8 single-port synchronous RAM, one-cycle read latency, write-first, contents never reset.
module gx4000_asic_bram
   import gx4000_asic_pkg::*;
#(
   parameter int unsigned AW = ASIC_ADDR_W,
   parameter int unsigned DW = 8
) (
   input  logic          clk_sys,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_q
);

   logic [DW-1:0] r_mem [0:(1<<AW)-1];
   logic [DW-1:0] r_q;

   always_ff @(posedge clk_sys) begin
      if (i_we) begin
         r_mem[i_addr] <= i_din;
         r_q           <= i_din;
      end else begin
         r_q <= r_mem[i_addr];
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/gx4000_asic_ram_ctrl.sv
// ASIC RAM responder: captures Z80 and video requests one deep and arbitrates them onto one RAM port,
// video first, with the CPU forced through after MAX_WAIT lost grant cycles.
module gx4000_asic_ram_ctrl
   import gx4000_asic_pkg::*;
#(
   parameter int unsigned       ADDR_W   = ASIC_ADDR_W,
   parameter int unsigned       MAX_WAIT = 3,
   parameter logic [ADDR_W-1:0] SPR_TOP  = SPR_PIX_TOP
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              i_plus_mode,
   input  logic              i_asic_en,
   input  logic [15:0]       i_cpu_addr,
   input  logic [7:0]        i_cpu_din,
   input  logic              i_cpu_wr,
   input  logic              i_cpu_rd,
   output logic [7:0]        o_cpu_dout,
   output logic              o_cpu_rdy,
   output logic              o_cpu_busy,
   input  logic [ADDR_W-1:0] i_vid_addr,
   input  logic              i_vid_rd,
   input  logic              i_vid_wr,
   input  logic [7:0]        i_vid_din,
   output logic [7:0]        o_vid_q,
   output logic              o_vid_ack,
   output logic              o_vid_ovf,
   output logic              o_cpu_err
);

   localparam logic [1:0] AGE_LIM = 2'(MAX_WAIT);

   logic              r_cpu_wr_q;
   logic              r_cpu_rd_q;
   asic_req_t         r_cpu_pend;
   asic_req_t         r_vid_pend;
   logic [1:0]        r_cpu_age;
   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic              r_cmp_rd;
   logic [7:0]        r_cpu_dout;
   logic [7:0]        r_vid_q;
   logic              r_vid_ovf;
   logic              r_cpu_err;

   logic              w_wr_edge;
   logic              w_rd_edge;
   logic              w_cpu_req;
   logic              w_cpu_busy;
   logic              w_vid_req;
   logic              w_gnt_cpu;
   logic              w_gnt_vid;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [7:0]        w_ram_din;
   logic [7:0]        w_ram_q;
   logic              w_cpu_load;
   logic              w_vid_load;

   assign w_wr_edge  = i_cpu_wr & ~r_cpu_wr_q;
   assign w_rd_edge  = i_cpu_rd & ~r_cpu_rd_q;
   assign w_cpu_req  = (w_wr_edge | w_rd_edge) & (i_cpu_addr[15:14] == ASIC_PAGE)
                       & i_asic_en & i_plus_mode;
   assign w_cpu_busy = r_cpu_pend.valid | (r_state == GNT_CPU);
   assign w_vid_req  = (i_vid_rd | i_vid_wr) & i_plus_mode;
   assign w_gnt_cpu  = (w_state_nxt == GNT_CPU);
   assign w_gnt_vid  = (w_state_nxt == GNT_VID);

   // Grant selection and RAM port mux; r_state then remembers who owns the in-flight access.
   always_comb begin
      w_state_nxt = IDLE;
      w_ram_we    = 1'b0;
      w_ram_addr  = '0;
      w_ram_din   = '0;
      if (!reset) begin
         if (r_cpu_pend.valid && (r_cpu_age == AGE_LIM))
            w_state_nxt = GNT_CPU;
         else if (r_vid_pend.valid)
            w_state_nxt = GNT_VID;
         else if (r_cpu_pend.valid)
            w_state_nxt = GNT_CPU;
      end
      case (w_state_nxt)
         GNT_VID: begin
            w_ram_we   = r_vid_pend.we;
            w_ram_addr = r_vid_pend.addr;
            w_ram_din  = spr_store_byte(r_vid_pend.addr, SPR_TOP, r_vid_pend.data);
         end
         GNT_CPU: begin
            w_ram_we   = r_cpu_pend.we;
            w_ram_addr = r_cpu_pend.addr;
            w_ram_din  = spr_store_byte(r_cpu_pend.addr, SPR_TOP, r_cpu_pend.data);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_sys) begin
      r_cpu_wr_q <= i_cpu_wr;
      r_cpu_rd_q <= i_cpu_rd;
      if (reset) begin
         r_cpu_pend.valid <= 1'b0;
         r_vid_pend.valid <= 1'b0;
         r_cpu_age        <= '0;
         r_cmp_rd         <= 1'b0;
         r_cpu_dout       <= '0;
         r_vid_q          <= '0;
         r_vid_ovf        <= 1'b0;
         r_cpu_err        <= 1'b0;
      end else begin
         if (w_cpu_req && !w_cpu_busy)
            r_cpu_pend <= '{valid: 1'b1, we: w_wr_edge, addr: i_cpu_addr[13:0], data: i_cpu_din};
         else if (w_gnt_cpu)
            r_cpu_pend.valid <= 1'b0;
         if (w_cpu_req && w_cpu_busy)
            r_cpu_err <= 1'b1;

         if (w_vid_req)
            r_vid_pend <= '{valid: 1'b1, we: i_vid_wr, addr: i_vid_addr, data: i_vid_din};
         else if (w_gnt_vid)
            r_vid_pend.valid <= 1'b0;
         if (w_vid_req && r_vid_pend.valid && !w_gnt_vid)
            r_vid_ovf <= 1'b1;

         if (w_gnt_cpu)
            r_cpu_age <= '0;
         else if (r_cpu_pend.valid && (r_cpu_age != 2'b11))
            r_cpu_age <= r_cpu_age + 2'd1;

         r_cmp_rd <= (w_state_nxt != IDLE) && !w_ram_we;
         if (w_cpu_load) r_cpu_dout <= w_ram_q;
         if (w_vid_load) r_vid_q    <= w_ram_q;
      end
   end

   gx4000_asic_bram #(
      .AW (ADDR_W),
      .DW (8)
   ) u_bram (
      .clk_sys (clk_sys),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_din   (w_ram_din),
      .o_q     (w_ram_q)
   );

   // Completion stage: read data is forwarded straight from the RAM in the ack/rdy cycle, then held.
   assign w_cpu_load = (r_state == GNT_CPU) & r_cmp_rd;
   assign w_vid_load = (r_state == GNT_VID) & r_cmp_rd;

   assign o_cpu_rdy  = (r_state == GNT_CPU) & ~reset;
   assign o_vid_ack  = (r_state == GNT_VID) & ~reset;
   assign o_cpu_dout = w_cpu_load ? w_ram_q : r_cpu_dout;
   assign o_vid_q    = w_vid_load ? w_ram_q : r_vid_q;
   assign o_cpu_busy = w_cpu_busy;
   assign o_vid_ovf  = r_vid_ovf;
   assign o_cpu_err  = r_cpu_err;

endmodule

// File: tb/tb_gx4000_asic_ram_ctrl.sv
// Directed and randomized bench for gx4000_asic_ram_ctrl against an array model of the ASIC RAM.
module tb_gx4000_asic_ram_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        i_plus_mode = 1'b1;
   logic        i_asic_en = 1'b1;
   logic [15:0] i_cpu_addr = '0;
   logic [7:0]  i_cpu_din = '0;
   logic        i_cpu_wr = 1'b0;
   logic        i_cpu_rd = 1'b0;
   logic [7:0]  o_cpu_dout;
   logic        o_cpu_rdy;
   logic        o_cpu_busy;
   logic [13:0] i_vid_addr = '0;
   logic        i_vid_rd = 1'b0;
   logic        i_vid_wr = 1'b0;
   logic [7:0]  i_vid_din = '0;
   logic [7:0]  o_vid_q;
   logic        o_vid_ack;
   logic        o_vid_ovf;
   logic        o_cpu_err;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [7:0]  m_mem [0:16383];
   logic [7:0]  exp_cpu_dout = 8'h00;
   logic [7:0]  exp_vid_q = 8'h00;

   always #5 clk_sys = ~clk_sys;

   gx4000_asic_ram_ctrl dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .i_plus_mode (i_plus_mode),
      .i_asic_en   (i_asic_en),
      .i_cpu_addr  (i_cpu_addr),
      .i_cpu_din   (i_cpu_din),
      .i_cpu_wr    (i_cpu_wr),
      .i_cpu_rd    (i_cpu_rd),
      .o_cpu_dout  (o_cpu_dout),
      .o_cpu_rdy   (o_cpu_rdy),
      .o_cpu_busy  (o_cpu_busy),
      .i_vid_addr  (i_vid_addr),
      .i_vid_rd    (i_vid_rd),
      .i_vid_wr    (i_vid_wr),
      .i_vid_din   (i_vid_din),
      .o_vid_q     (o_vid_q),
      .o_vid_ack   (o_vid_ack),
      .o_vid_ovf   (o_vid_ovf),
      .o_cpu_err   (o_cpu_err)
   );

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Sprite pixel region 0x0000..0x0FFF keeps only the low nibble.
   function automatic void mwrite(input logic [13:0] a, input logic [7:0] d);
      m_mem[a] = (a < 14'h1000) ? {4'h0, d[3:0]} : d;
   endfunction

   task automatic cpu_access(input bit we, input logic [13:0] a, input logic [7:0] d);
      i_cpu_addr = {2'b01, a};
      i_cpu_din  = d;
      if (we) i_cpu_wr = 1'b1;
      else    i_cpu_rd = 1'b1;
      step();
      chk1("cpu_busy_c1", o_cpu_busy, 1'b1);
      chk1("cpu_rdy_c1", o_cpu_rdy, 1'b0);
      step();
      chk1("cpu_rdy_c2", o_cpu_rdy, 1'b1);
      chk1("cpu_busy_c2", o_cpu_busy, 1'b1);
      if (we) mwrite(a, d);
      else    exp_cpu_dout = m_mem[a];
      chk8("cpu_dout_c2", o_cpu_dout, exp_cpu_dout);
      i_cpu_wr = 1'b0;
      i_cpu_rd = 1'b0;
      step();
      chk1("cpu_rdy_c3", o_cpu_rdy, 1'b0);
      chk1("cpu_busy_c3", o_cpu_busy, 1'b0);
      chk8("cpu_dout_hold", o_cpu_dout, exp_cpu_dout);
   endtask

   task automatic vid_access(input bit we, input logic [13:0] a, input logic [7:0] d);
      i_vid_addr = a;
      i_vid_din  = d;
      if (we) i_vid_wr = 1'b1;
      else    i_vid_rd = 1'b1;
      step();
      i_vid_wr = 1'b0;
      i_vid_rd = 1'b0;
      chk1("vid_ack_c1", o_vid_ack, 1'b0);
      step();
      chk1("vid_ack_c2", o_vid_ack, 1'b1);
      if (we) mwrite(a, d);
      else    exp_vid_q = m_mem[a];
      chk8("vid_q_c2", o_vid_q, exp_vid_q);
      step();
      chk1("vid_ack_c3", o_vid_ack, 1'b0);
      chk8("vid_q_hold", o_vid_q, exp_vid_q);
   endtask

   initial begin
      logic [7:0]  d;
      logic [7:0]  d2;
      logic [13:0] pool [0:5];

      // Reset state
      step();
      step();
      chk8("rst_cpu_dout", o_cpu_dout, 8'h00);
      chk1("rst_cpu_rdy", o_cpu_rdy, 1'b0);
      chk1("rst_cpu_busy", o_cpu_busy, 1'b0);
      chk8("rst_vid_q", o_vid_q, 8'h00);
      chk1("rst_vid_ack", o_vid_ack, 1'b0);
      chk1("rst_vid_ovf", o_vid_ovf, 1'b0);
      chk1("rst_cpu_err", o_cpu_err, 1'b0);
      reset = 1'b0;
      step();

      // CPU write then read outside the sprite region
      cpu_access(1'b1, 14'h1234, 8'hA7);
      cpu_access(1'b0, 14'h1234, 8'h00);
      chk8("cpu_rw_a7", o_cpu_dout, 8'hA7);

      // Nibble masking in the sprite region, full byte above it
      vid_access(1'b1, 14'h0010, 8'hFF);
      vid_access(1'b0, 14'h0010, 8'h00);
      chk8("vid_nibble", o_vid_q, 8'h0F);
      vid_access(1'b1, 14'h2000, 8'hFF);
      vid_access(1'b0, 14'h2000, 8'h00);
      chk8("vid_full", o_vid_q, 8'hFF);

      // Starvation bound: video reads every cycle against one CPU write
      d = 8'($urandom);
      i_cpu_addr = 16'h4100;
      i_cpu_din  = d;
      i_cpu_wr   = 1'b1;
      i_vid_addr = 14'h0010;
      i_vid_rd   = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk1("starve_rdy", o_cpu_rdy, k == 5);
         chk1("starve_ack", o_vid_ack, (k >= 2 && k <= 4) || k == 6 || k == 7);
         chk1("starve_ovf", o_vid_ovf, k >= 5);
         if (o_vid_ack) chk8("starve_vid_q", o_vid_q, 8'h0F);
         if (k == 5) mwrite(14'h0100, d);
         if (k == 6) begin
            i_vid_rd = 1'b0;
            i_cpu_wr = 1'b0;
         end
      end
      exp_vid_q = 8'h0F;
      cpu_access(1'b0, 14'h0100, 8'h00);

      // Same-address collision: video first, CPU last
      for (int c = 0; c < 2; c++) begin
         logic [13:0] a;
         a = (c == 0) ? 14'h0300 : 14'h1300;
         i_vid_addr = a;
         i_vid_din  = 8'h11;
         i_vid_wr   = 1'b1;
         i_cpu_addr = {2'b01, a};
         i_cpu_din  = 8'h22;
         i_cpu_wr   = 1'b1;
         step();
         i_vid_wr = 1'b0;
         step();
         chk1("coll_vid_ack", o_vid_ack, 1'b1);
         chk1("coll_cpu_rdy_early", o_cpu_rdy, 1'b0);
         step();
         chk1("coll_cpu_rdy", o_cpu_rdy, 1'b1);
         chk1("coll_vid_ack_late", o_vid_ack, 1'b0);
         i_cpu_wr = 1'b0;
         mwrite(a, 8'h11);
         mwrite(a, 8'h22);
         step();
         cpu_access(1'b0, a, 8'h00);
      end
      chk8("coll_full_22", o_cpu_dout, 8'h22);

      // Read granted the cycle after a write to the same address
      d = 8'($urandom);
      i_vid_addr = 14'h2100;
      i_vid_din  = d;
      i_vid_wr   = 1'b1;
      step();
      i_vid_wr   = 1'b0;
      i_cpu_addr = 16'h6100;
      i_cpu_rd   = 1'b1;
      mwrite(14'h2100, d);
      step();
      chk1("raw_vid_ack", o_vid_ack, 1'b1);
      step();
      chk1("raw_cpu_rdy", o_cpu_rdy, 1'b1);
      chk8("raw_cpu_dout", o_cpu_dout, d);
      exp_cpu_dout = d;
      i_cpu_rd = 1'b0;
      step();

      // Second edge while busy is dropped and flagged
      d  = 8'($urandom);
      d2 = ~d;
      cpu_access(1'b1, 14'h1400, d);
      chk1("err_before", o_cpu_err, 1'b0);
      i_cpu_addr = 16'h5400;
      i_cpu_rd   = 1'b1;
      step();
      i_cpu_din = d2;
      i_cpu_wr  = 1'b1;
      step();
      chk1("err_rdy", o_cpu_rdy, 1'b1);
      chk8("err_read", o_cpu_dout, d);
      chk1("err_set", o_cpu_err, 1'b1);
      exp_cpu_dout = d;
      step();
      chk1("err_no_second", o_cpu_busy, 1'b0);
      i_cpu_wr = 1'b0;
      i_cpu_rd = 1'b0;
      step();
      cpu_access(1'b0, 14'h1400, 8'h00);
      chk8("err_ram_kept", o_cpu_dout, d);

      // Reset one cycle after a video read request
      i_vid_addr = 14'h2000;
      i_vid_rd   = 1'b1;
      step();
      i_vid_rd = 1'b0;
      reset    = 1'b1;
      step();
      chk1("mrst_vid_ack", o_vid_ack, 1'b0);
      chk1("mrst_vid_ovf", o_vid_ovf, 1'b0);
      chk1("mrst_cpu_err", o_cpu_err, 1'b0);
      chk8("mrst_cpu_dout", o_cpu_dout, 8'h00);
      chk8("mrst_vid_q", o_vid_q, 8'h00);
      chk1("mrst_cpu_busy", o_cpu_busy, 1'b0);
      reset = 1'b0;
      exp_cpu_dout = 8'h00;
      exp_vid_q    = 8'h00;
      step();
      chk1("mrst_vid_ack_after", o_vid_ack, 1'b0);

      // plus_mode low ignores new requests
      d = 8'($urandom);
      cpu_access(1'b1, 14'h1500, d);
      i_plus_mode = 1'b0;
      i_cpu_addr  = 16'h5500;
      i_cpu_din   = ~d;
      i_cpu_wr    = 1'b1;
      i_vid_addr  = 14'h1500;
      i_vid_rd    = 1'b1;
      step();
      i_vid_rd = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk1("plus_cpu_rdy", o_cpu_rdy, 1'b0);
         chk1("plus_cpu_busy", o_cpu_busy, 1'b0);
         chk1("plus_vid_ack", o_vid_ack, 1'b0);
         step();
      end
      i_cpu_wr    = 1'b0;
      step();
      i_plus_mode = 1'b1;
      cpu_access(1'b0, 14'h1500, 8'h00);
      chk8("plus_ram_kept", o_cpu_dout, d);

      // Randomized uncontested traffic over a small address pool
      for (int i = 0; i < 6; i++) begin
         pool[i] = (i < 3) ? 14'($urandom_range(0, 14'h0FFF)) : 14'($urandom);
         if (i % 2 == 0) cpu_access(1'b1, pool[i], 8'($urandom));
         else            vid_access(1'b1, pool[i], 8'($urandom));
      end
      for (int i = 0; i < 30; i++) begin
         int  sel;
         bit  we;
         sel = $urandom_range(0, 5);
         we  = 1'($urandom);
         if (1'($urandom)) cpu_access(we, pool[sel], 8'($urandom));
         else              vid_access(we, pool[sel], 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
